rtc_bus_arbiter: RTL and testbench
==================================

RTC_BUS_ARBITER -- requirements
Module: rtc_bus_arbiter

Interface
REQ-001 The block SHALL have parameter T_SETUP, default 2, giving the address setup cycles before the address strobe (legal range 1..15).
REQ-002 The block SHALL have parameter T_PULSE, default 4, giving the RD/WR strobe width in cycles (legal range 1..15).
REQ-003 The block SHALL have parameter T_GAP, default 2, giving the inter-phase gap and recovery cycles (legal range 1..15).
REQ-004 The block SHALL have these ports:
- clk  in  1  system clock; every flop samples on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- req0  in  1  request from requester 0 (PicoBlaze port side); level, held until done0.
- we0  in  1  requester 0 direction: 1 = write, 0 = read.
- addr0  in  8  requester 0 RTC register address.
- wdata0  in  8  requester 0 write data.
- done0  out  1  one-cycle pulse when requester 0's transaction completes.
- req1, we1, addr1, wdata1, done1  same as above, for requester 1 (automatic time-refresh scanner).
- rdata  out  8  data captured by the last completed read.
- busy  out  1  high while a transaction is in progress (not IDLE).
- gnt  out  1  index of the requester owning the current or last transaction.
- CS  out  1  RTC chip select, active-low.
- AD  out  1  RTC address/data select: 0 = address phase, 1 = data phase.
- RD  out  1  RTC read strobe, active-low.
- WR  out  1  RTC write/latch strobe, active-low.
- bus_out  out  8  value driven onto the multiplexed RTC bus.
- bus_oe  out  1  bus output enable; the top-level tristate drives bus_out when this is 1.
- bus_in  in  8  sampled RTC bus value.

Function
REQ-005 The FSM SHALL have the states IDLE, ADDR_SETUP, ADDR_STROBE, GAP, DATA and RECOVER, with a 4-bit phase counter.
REQ-006 In IDLE, CS/AD/RD/WR SHALL be 1, bus_oe 0 and busy 0.
REQ-007 In IDLE with any req high, the block SHALL grant one requester, latch its we/addr/wdata, update gnt and enter ADDR_SETUP on the next edge.
REQ-008 Arbitration SHALL be round-robin.
- A priority pointer favours one requester when both are high in the same IDLE cycle.
- The pointer moves to the other requester after each grant.
- The pointer resets to favour requester 0.
- A single requester is always granted regardless of the pointer.
REQ-009 ADDR_SETUP SHALL last T_SETUP cycles with CS=0, AD=0, bus_oe=1, bus_out=latched addr.
REQ-010 ADDR_STROBE SHALL last T_PULSE cycles with ADDR_SETUP outputs plus WR=0.
REQ-011 GAP SHALL last T_GAP cycles with CS=1, WR=1, RD=1, AD=0 and bus_oe=0.
REQ-012 DATA SHALL last T_PULSE cycles with CS=0 and AD=1.
- Write: bus_oe=1, bus_out=latched wdata, WR=0.
- Read: bus_oe=0, RD=0.
REQ-013 For a read, rdata SHALL load bus_in on the edge ending the last DATA cycle and hold it until the next completed read; writes leave rdata unchanged.
REQ-014 RECOVER SHALL last T_GAP cycles with all strobes 1 and bus_oe=0, then return to IDLE.
REQ-015 done of the granted requester SHALL pulse high for exactly the first IDLE cycle after RECOVER; the other done SHALL stay 0.
REQ-016 The total transaction SHALL take T_SETUP+2*T_PULSE+2*T_GAP cycles from the first ADDR_SETUP cycle; with defaults that is 14, and done occurs 15 cycles after the grant cycle.
REQ-017 A new grant SHALL be allowed in the same IDLE cycle that done pulses, giving back-to-back transactions with one IDLE cycle between them.
REQ-018 Changes on req/we/addr/wdata after the grant SHALL be ignored until the transaction completes; dropping req mid-transaction SHALL NOT abort it.
REQ-019 RD and WR SHALL never be 0 simultaneously, and bus_oe SHALL be 0 whenever RD=0.

Reset
REQ-020 rst=0 SHALL immediately, without waiting for clk, force IDLE, CS=AD=RD=WR=1, bus_oe=0, bus_out=0x00, rdata=0x00, busy=0, gnt=0, done0=done1=0 and pointer to requester 0.
REQ-021 Reset asserted mid-transaction SHALL abort it with no done pulse; the first grant after release SHALL follow REQ-007.

Verification
REQ-022 Write: req0=1, we0=1, addr0=0x21, wdata0=0x45 -> bus_out=0x21 with AD=0 and WR=0 for 4 cycles, then 0x45 with AD=1 and WR=0 for 4 cycles, then done0 pulses 15 cycles after the grant.
REQ-023 Read: req1=1, we1=0, addr1=0x22, bus_in=0x59 during DATA -> RD=0 for 4 cycles with bus_oe=0, then rdata=0x59 and done1 pulses; done0 stays 0.
REQ-024 Contention: req0 and req1 rise in the same IDLE cycle after reset and stay high -> grant order is 0, 1, 0, 1 with one IDLE cycle between transactions.
REQ-025 Reset mid-transaction: rst=0 during DATA of a write -> all strobes go 1 and bus_oe 0 asynchronously, no done pulse; after release, req0 held high is granted again.
REQ-026 Parameters: build with T_SETUP=1, T_PULSE=1, T_GAP=1 -> transaction is 5 cycles, and a checker confirms REQ-019 on every cycle.

Source files
------------

// File: rtl/rtc_bus_arbiter_if.sv
// Bundle of the two requester ports and the multiplexed RTC bus pins.
// The arbiter uses the master view; whatever drives the requests and
// models the RTC chip uses the slave view.
`timescale 1ns/1ps

interface rtc_bus_arbiter_if;
  logic       req0;
  logic       we0;
  logic [7:0] addr0;
  logic [7:0] wdata0;
  logic       done0;
  logic       req1;
  logic       we1;
  logic [7:0] addr1;
  logic [7:0] wdata1;
  logic       done1;
  logic [7:0] rdata;
  logic       busy;
  logic       gnt;
  logic       CS;
  logic       AD;
  logic       RD;
  logic       WR;
  logic [7:0] bus_out;
  logic       bus_oe;
  logic [7:0] bus_in;

  modport master (
    input  req0, we0, addr0, wdata0,
    input  req1, we1, addr1, wdata1,
    input  bus_in,
    output done0, done1, rdata, busy, gnt,
    output CS, AD, RD, WR, bus_out, bus_oe
  );

  modport slave (
    output req0, we0, addr0, wdata0,
    output req1, we1, addr1, wdata1,
    output bus_in,
    input  done0, done1, rdata, busy, gnt,
    input  CS, AD, RD, WR, bus_out, bus_oe
  );
endinterface

// File: rtl/rtc_bus_arbiter.sv
// Two-requester round-robin arbiter driving a multiplexed address/data RTC
// bus. A transaction is address setup, address latch strobe, gap, data
// strobe and recovery, each phase timed by a shared 4-bit down counter.
`timescale 1ns/1ps

module rtc_bus_arbiter #(
  parameter int T_SETUP = 2,
  parameter int T_PULSE = 4,
  parameter int T_GAP   = 2
) (
  input logic              clk,
  input logic              rst,
  rtc_bus_arbiter_if.master bus
);

  localparam logic [3:0] SETUP_LAST = 4'(T_SETUP - 1);
  localparam logic [3:0] PULSE_LAST = 4'(T_PULSE - 1);
  localparam logic [3:0] GAP_LAST   = 4'(T_GAP - 1);

  typedef enum logic [2:0] {
    IDLE,
    ADDR_SETUP,
    ADDR_STROBE,
    GAP,
    DATA,
    RECOVER
  } state_t;

  state_t     state;
  state_t     next_state;
  logic [3:0] phase_cnt;
  logic [3:0] next_cnt;
  logic       phase_end;
  logic       ptr;
  logic       grant_valid;
  logic       grant_idx;
  logic       gnt_q;
  logic       we_q;
  logic       done_q;
  logic [7:0] addr_q;
  logic [7:0] wdata_q;
  logic [7:0] rdata_q;

  assign phase_end = (phase_cnt == 4'd0);

  // Pick a requester: the pointer only matters when both are asking.
  always_comb begin
    grant_valid = bus.req0 | bus.req1;
    grant_idx   = 1'b0;
    if (bus.req0 && bus.req1) begin
      grant_idx = ptr;
    end else if (bus.req1) begin
      grant_idx = 1'b1;
    end
  end

  // Phase sequencing; each phase reloads the counter with its length minus one.
  always_comb begin
    next_state = state;
    next_cnt   = phase_cnt - 4'd1;
    case (state)
      IDLE: begin
        next_cnt = 4'd0;
        if (grant_valid) begin
          next_state = ADDR_SETUP;
          next_cnt   = SETUP_LAST;
        end
      end
      ADDR_SETUP: if (phase_end) begin
        next_state = ADDR_STROBE;
        next_cnt   = PULSE_LAST;
      end
      ADDR_STROBE: if (phase_end) begin
        next_state = GAP;
        next_cnt   = GAP_LAST;
      end
      GAP: if (phase_end) begin
        next_state = DATA;
        next_cnt   = PULSE_LAST;
      end
      DATA: if (phase_end) begin
        next_state = RECOVER;
        next_cnt   = GAP_LAST;
      end
      RECOVER: if (phase_end) begin
        next_state = IDLE;
        next_cnt   = 4'd0;
      end
      default: begin
        next_state = IDLE;
        next_cnt   = 4'd0;
      end
    endcase
  end

  // Bus pins decoded purely from the state so reset forces them immediately.
  always_comb begin
    bus.CS      = 1'b1;
    bus.AD      = 1'b1;
    bus.RD      = 1'b1;
    bus.WR      = 1'b1;
    bus.bus_oe  = 1'b0;
    bus.bus_out = 8'h00;
    case (state)
      ADDR_SETUP: begin
        bus.CS      = 1'b0;
        bus.AD      = 1'b0;
        bus.bus_oe  = 1'b1;
        bus.bus_out = addr_q;
      end
      ADDR_STROBE: begin
        bus.CS      = 1'b0;
        bus.AD      = 1'b0;
        bus.WR      = 1'b0;
        bus.bus_oe  = 1'b1;
        bus.bus_out = addr_q;
      end
      GAP: begin
        bus.AD = 1'b0;
      end
      DATA: begin
        bus.CS = 1'b0;
        bus.AD = 1'b1;
        if (we_q) begin
          bus.bus_oe  = 1'b1;
          bus.bus_out = wdata_q;
          bus.WR      = 1'b0;
        end else begin
          bus.RD = 1'b0;
        end
      end
      default: ;
    endcase
  end

  // State register and phase counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      phase_cnt <= 4'd0;
    end else begin
      state     <= next_state;
      phase_cnt <= next_cnt;
    end
  end

  // Grant bookkeeping, request latching, read capture and completion flag.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr     <= 1'b0;
      gnt_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= 8'h00;
      wdata_q <= 8'h00;
      rdata_q <= 8'h00;
      done_q  <= 1'b0;
    end else begin
      done_q <= (state == RECOVER) && phase_end;
      if (state == IDLE && grant_valid) begin
        gnt_q   <= grant_idx;
        ptr     <= ~grant_idx;
        we_q    <= grant_idx ? bus.we1    : bus.we0;
        addr_q  <= grant_idx ? bus.addr1  : bus.addr0;
        wdata_q <= grant_idx ? bus.wdata1 : bus.wdata0;
      end
      if (state == DATA && phase_end && !we_q) begin
        rdata_q <= bus.bus_in;
      end
    end
  end

  assign bus.rdata = rdata_q;
  assign bus.busy  = (state != IDLE);
  assign bus.gnt   = gnt_q;
  assign bus.done0 = done_q & ~gnt_q;
  assign bus.done1 = done_q & gnt_q;

endmodule

// File: tb/tb_rtc_bus_arbiter.sv
// Bench for rtc_bus_arbiter: a default-timing instance and a fastest-timing
// instance, a vector table of single transactions checked cycle by cycle,
// a done-pulse scoreboard, and hand-written contention and reset sequences.
`timescale 1ns/1ps

module tb_rtc_bus_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   cyc = 0;
  int   nChk = 0;
  int   nErr = 0;

  localparam logic [16:0] RESET_VEC = 17'h1E000;

  typedef struct {
    bit         idx;
    bit         we;
    logic [7:0] addr;
    logic [7:0] wdata;
    logic [7:0] bin;
    bit         drop;
    bit         exp_gnt;
    logic [7:0] exp_rdata;
  } vec_t;

  typedef struct {
    bit         idx;
    int         cyc;
    logic [7:0] rdata;
  } sb_t;

  sb_t  sb_d[$];
  sb_t  sb_f[$];
  sb_t  ed_d;
  sb_t  ed_f;
  vec_t tbl[6];
  vec_t vr;
  int   g;

  rtc_bus_arbiter_if if_d ();
  rtc_bus_arbiter_if if_f ();

  rtc_bus_arbiter dut (
    .clk (clk),
    .rst (rst),
    .bus (if_d)
  );

  rtc_bus_arbiter #(.T_SETUP(1), .T_PULSE(1), .T_GAP(1)) dut_fast (
    .clk (clk),
    .rst (rst),
    .bus (if_f)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChk++;
    if (act !== exp) begin
      nErr++;
      $display("[TB] FAIL %s: got %h expected %h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  task automatic applyStimulus(input bit fast, input bit idx, input bit req, input bit we,
                               input logic [7:0] addr, input logic [7:0] wdata);
    if (!fast) begin
      if (!idx) begin
        if_d.req0 = req; if_d.we0 = we; if_d.addr0 = addr; if_d.wdata0 = wdata;
      end else begin
        if_d.req1 = req; if_d.we1 = we; if_d.addr1 = addr; if_d.wdata1 = wdata;
      end
    end else begin
      if (!idx) begin
        if_f.req0 = req; if_f.we0 = we; if_f.addr0 = addr; if_f.wdata0 = wdata;
      end else begin
        if_f.req1 = req; if_f.we1 = we; if_f.addr1 = addr; if_f.wdata1 = wdata;
      end
    end
  endtask

  task automatic setBusIn(input bit fast, input logic [7:0] val);
    if (fast) if_f.bus_in = val;
    else      if_d.bus_in = val;
  endtask

  function automatic logic [16:0] obs(input bit fast);
    if (fast)
      return {if_f.CS, if_f.AD, if_f.RD, if_f.WR, if_f.bus_oe, if_f.busy,
              if_f.gnt, if_f.done1, if_f.done0, if_f.bus_out};
    return {if_d.CS, if_d.AD, if_d.RD, if_d.WR, if_d.bus_oe, if_d.busy,
            if_d.gnt, if_d.done1, if_d.done0, if_d.bus_out};
  endfunction

  // Expected pins k cycles after the grant cycle, from the phase lengths alone.
  function automatic logic [16:0] expBus(input int k, input vec_t v,
                                         input int ts, input int tp, input int tg);
    int e1 = ts;
    int e2 = ts + tp;
    int e3 = ts + tp + tg;
    int e4 = ts + 2 * tp + tg;
    int e5 = ts + 2 * tp + 2 * tg;
    logic cs = 1'b1, ad = 1'b1, rd = 1'b1, wr = 1'b1, oe = 1'b0, bsy = 1'b1;
    logic d0 = 1'b0, d1 = 1'b0;
    logic [7:0] bo = 8'h00;
    if (k <= e1) begin
      cs = 1'b0; ad = 1'b0; oe = 1'b1; bo = v.addr;
    end else if (k <= e2) begin
      cs = 1'b0; ad = 1'b0; oe = 1'b1; bo = v.addr; wr = 1'b0;
    end else if (k <= e3) begin
      ad = 1'b0;
    end else if (k <= e4) begin
      cs = 1'b0;
      if (v.we) begin
        oe = 1'b1; bo = v.wdata; wr = 1'b0;
      end else begin
        rd = 1'b0;
      end
    end else if (k > e5) begin
      bsy = 1'b0; d0 = ~v.exp_gnt; d1 = v.exp_gnt;
    end
    return {cs, ad, rd, wr, oe, bsy, v.exp_gnt, d1, d0, bo};
  endfunction

  task automatic waitIdle(input bit fast);
    int n = 0;
    @(negedge clk);
    while ((fast ? if_f.busy : if_d.busy) && n < 100) begin
      @(negedge clk);
      n++;
    end
    checkOutput("wait_idle", 32'(fast ? if_f.busy : if_d.busy), 32'd0);
  endtask

  // One transaction checked every cycle; pre=1 means the request is already held.
  task automatic runTxn(input bit fast, input vec_t v, input bit pre);
    int ts, tp, tg, tot, gc;
    logic [16:0] e, a;
    sb_t s;
    ts  = fast ? 1 : 2;
    tp  = fast ? 1 : 4;
    tg  = fast ? 1 : 2;
    tot = ts + 2 * tp + 2 * tg;
    if (!pre) begin
      @(posedge clk); #1;
      applyStimulus(fast, v.idx, 1'b1, v.we, v.addr, v.wdata);
    end
    gc = cyc;
    s.idx = v.exp_gnt; s.cyc = gc + tot + 1; s.rdata = v.exp_rdata;
    if (fast) sb_f.push_back(s);
    else      sb_d.push_back(s);
    for (int k = 1; k <= tot + 1; k++) begin
      @(posedge clk); #1;
      if (k == 1 && v.drop) applyStimulus(fast, v.idx, 1'b0, ~v.we, ~v.addr, ~v.wdata);
      if (k == tot + 1)     applyStimulus(fast, v.idx, 1'b0, v.we, v.addr, v.wdata);
      setBusIn(fast, (k == tot - tg && !v.we) ? v.bin : ~v.bin);
      @(negedge clk);
      e = expBus(k, v, ts, tp, tg);
      a = obs(fast);
      if (!e[12]) a[7:0] = 8'h00;
      checkOutput(fast ? "txn_fast" : "txn_dflt", 32'(a), 32'(e));
    end
  endtask

  // Completion scoreboard for the default-timing instance.
  always @(negedge clk) begin
    if (if_d.done0 || if_d.done1) begin
      if (sb_d.size() == 0) begin
        nChk++; nErr++;
        $display("[TB] FAIL done_dflt: got done0=%b done1=%b expected no done at cycle %0d",
                 if_d.done0, if_d.done1, cyc);
      end else begin
        ed_d = sb_d.pop_front();
        checkOutput("done_dflt",
                    {4'h0, cyc[15:0], if_d.rdata, if_d.busy, if_d.gnt, if_d.done1, if_d.done0},
                    {4'h0, ed_d.cyc[15:0], ed_d.rdata, 1'b0, ed_d.idx, ed_d.idx, ~ed_d.idx});
      end
    end
  end

  // Completion scoreboard for the fastest-timing instance.
  always @(negedge clk) begin
    if (if_f.done0 || if_f.done1) begin
      if (sb_f.size() == 0) begin
        nChk++; nErr++;
        $display("[TB] FAIL done_fast: got done0=%b done1=%b expected no done at cycle %0d",
                 if_f.done0, if_f.done1, cyc);
      end else begin
        ed_f = sb_f.pop_front();
        checkOutput("done_fast",
                    {4'h0, cyc[15:0], if_f.rdata, if_f.busy, if_f.gnt, if_f.done1, if_f.done0},
                    {4'h0, ed_f.cyc[15:0], ed_f.rdata, 1'b0, ed_f.idx, ed_f.idx, ~ed_f.idx});
      end
    end
  end

  // RD and WR never low together, and nothing drives the bus while RD is low.
  always @(negedge clk) begin
    checkOutput("strobe_excl_dflt",
                {30'd0, !(!if_d.RD && !if_d.WR), !(!if_d.RD && if_d.bus_oe)}, 32'h3);
    checkOutput("strobe_excl_fast",
                {30'd0, !(!if_f.RD && !if_f.WR), !(!if_f.RD && if_f.bus_oe)}, 32'h3);
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got no completion expected finish before 200000ns");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    tbl[0] = '{idx:1'b0, we:1'b1, addr:8'h21, wdata:8'h45, bin:8'h00, drop:1'b0, exp_gnt:1'b0, exp_rdata:8'h00};
    tbl[1] = '{idx:1'b0, we:1'b0, addr:8'h30, wdata:8'h99, bin:8'hA5, drop:1'b1, exp_gnt:1'b0, exp_rdata:8'hA5};
    tbl[2] = '{idx:1'b1, we:1'b0, addr:8'h22, wdata:8'h00, bin:8'h59, drop:1'b0, exp_gnt:1'b1, exp_rdata:8'h59};
    tbl[3] = '{idx:1'b1, we:1'b1, addr:8'h7F, wdata:8'h3C, bin:8'h12, drop:1'b0, exp_gnt:1'b1, exp_rdata:8'h59};
    tbl[4] = '{idx:1'b0, we:1'b1, addr:8'h00, wdata:8'hFF, bin:8'h34, drop:1'b1, exp_gnt:1'b0, exp_rdata:8'h59};
    tbl[5] = '{idx:1'b1, we:1'b0, addr:8'hFF, wdata:8'h00, bin:8'h00, drop:1'b0, exp_gnt:1'b1, exp_rdata:8'h00};

    for (int f = 0; f < 2; f++) begin
      applyStimulus(f[0], 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
      applyStimulus(f[0], 1'b1, 1'b0, 1'b0, 8'h00, 8'h00);
      setBusIn(f[0], 8'h00);
    end

    #3;
    checkOutput("reset_pins_dflt", 32'(obs(1'b0)), 32'(RESET_VEC));
    checkOutput("reset_pins_fast", 32'(obs(1'b1)), 32'(RESET_VEC));
    checkOutput("reset_rdata", {16'd0, if_d.rdata, if_f.rdata}, 32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;

    for (int i = 0; i < 6; i++) begin
      waitIdle(1'b0);
      runTxn(1'b0, tbl[i], 1'b0);
    end
    for (int i = 0; i < 6; i++) begin
      waitIdle(1'b1);
      runTxn(1'b1, tbl[i], 1'b0);
    end

    $display("[TB] contention after reset");
    @(posedge clk); #1 rst = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 8'h11, 8'h22);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 8'h33, 8'h44);
    setBusIn(1'b0, 8'h66);
    g = cyc;
    sb_d.push_back('{idx:1'b0, cyc:g + 15, rdata:8'h00});
    sb_d.push_back('{idx:1'b1, cyc:g + 30, rdata:8'h66});
    sb_d.push_back('{idx:1'b0, cyc:g + 45, rdata:8'h66});
    sb_d.push_back('{idx:1'b1, cyc:g + 60, rdata:8'h66});
    repeat (60) @(posedge clk);
    #1;
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00);
    repeat (20) @(negedge clk);
    checkOutput("contention_drained", 32'(sb_d.size()), 32'd0);
    checkOutput("contention_idle", 32'(if_d.busy), 32'd0);

    $display("[TB] reset during data phase");
    vr = '{idx:1'b0, we:1'b1, addr:8'h21, wdata:8'h45, bin:8'h00, drop:1'b0, exp_gnt:1'b0, exp_rdata:8'h00};
    @(posedge clk); #1;
    applyStimulus(1'b0, 1'b0, 1'b1, vr.we, vr.addr, vr.wdata);
    repeat (10) @(posedge clk);
    #2;
    checkOutput("pre_reset_data", 32'(obs(1'b0)), 32'(expBus(10, vr, 2, 4, 2)));
    #1 rst = 1'b0;
    #1;
    checkOutput("reset_async_pins", 32'(obs(1'b0)), 32'(RESET_VEC));
    checkOutput("reset_async_rdata", 32'(if_d.rdata), 32'd0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    runTxn(1'b0, vr, 1'b1);

    repeat (3) @(negedge clk);
    checkOutput("scoreboard_empty", 32'(sb_d.size() + sb_f.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", nErr, nChk);
    $finish;
  end

endmodule
